// File: rtl/warp_pkg.sv
// Shared types for the per-warp scheduler context: update kinds, slot FSM
// states and reconvergence-stack entry kinds.
package warp_pkg;

  typedef enum logic [2:0] {
    UPD_NEXT   = 3'd0,
    UPD_BRA    = 3'd1,
    UPD_SSY    = 3'd2,
    UPD_SYNC   = 3'd3,
    UPD_BAR    = 3'd4,
    UPD_EXIT   = 3'd5,
    UPD_REPLAY = 3'd6
  } upd_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READY    = 2'd1,
    ST_ISSUED   = 2'd2,
    ST_BAR_WAIT = 2'd3
  } warp_state_e;

  typedef enum logic {
    STK_DIV  = 1'b0,
    STK_SYNC = 1'b1
  } stk_kind_e;

  function automatic int bar_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warp_rstack.sv
// Register-based LIFO for SIMT reconvergence entries; overflow pushes and
// empty pops are dropped, the owner reports them.
module warp_rstack #(
  parameter  int DEPTH = 4,
  parameter  int E_W   = 43,
  localparam int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [E_W-1:0]  din,
  output logic [E_W-1:0]  top,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  logic [DEPTH-1:0][E_W-1:0] ent;

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent <= '0;
      sp  <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++)
        if (SP_W'(i) == sp) ent[i] <= din;
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (SP_W'(i + 1) == sp) top = ent[i];
  end

endmodule

// File: rtl/warp_slot.sv
// Per-warp scheduler context: identity, PC, active mask, reconvergence stack,
// named barriers. Optional REPLAY counter under WARP_SLOT_REPLAY_CNT_EN.
module warp_slot
  import warp_pkg::*;
#(
  parameter  int NUM_WARPS    = 16,
  parameter  int NUM_BLOCKS   = 8,
  parameter  int I_ADDR_WIDTH = 10,
  parameter  int R_ADDR_WIDTH = 10,
  parameter  int WARP_WIDTH   = 32,
  parameter  int STACK_DEPTH  = 4,
  parameter  int NUM_BARRIERS = 2,
  localparam int WID_W        = $clog2(NUM_WARPS),
  localparam int BID_W        = $clog2(NUM_BLOCKS),
  localparam int SP_W         = $clog2(STACK_DEPTH + 1),
  localparam int BAR_W        = bar_w(NUM_BARRIERS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_en,
  input  logic [WID_W-1:0]        init_wid,
  input  logic [BID_W-1:0]        init_bid,
  input  logic [I_ADDR_WIDTH-1:0] init_pc,
  input  logic [R_ADDR_WIDTH-1:0] init_base,
  input  logic [R_ADDR_WIDTH-1:0] init_rpt,
  input  logic [WARP_WIDTH-1:0]   init_mask,
  input  logic                    issue_en,
  input  logic [WID_W-1:0]        issue_wid,
  input  logic                    upd_en,
  input  logic [WID_W-1:0]        upd_wid,
  input  logic [2:0]              upd_kind,
  input  logic [I_ADDR_WIDTH-1:0] upd_pc_p1,
  input  logic [I_ADDR_WIDTH-1:0] upd_target,
  input  logic [WARP_WIDTH-1:0]   upd_taken,
  input  logic [BAR_W-1:0]        upd_bar,
  input  logic                    rel_en,
  input  logic [BID_W-1:0]        rel_bid,
  input  logic [BAR_W-1:0]        rel_bar,
  output logic                    ready,
  output logic                    valid_o,
  output logic [I_ADDR_WIDTH-1:0] pc_o,
  output logic [WARP_WIDTH-1:0]   mask_o,
  output logic [WID_W-1:0]        wid_o,
  output logic [BID_W-1:0]        bid_o,
  output logic [R_ADDR_WIDTH-1:0] base_addr_o,
  output logic [R_ADDR_WIDTH-1:0] rpt_o,
  output logic                    bar_wait_o,
  output logic [SP_W-1:0]         sp_o,
`ifdef WARP_SLOT_REPLAY_CNT_EN
  output logic [7:0]              replay_cnt_o,
`endif
  output logic                    stk_err_o
);

  // Entry layout depends on module parameters, so it lives here, not in the package.
  typedef struct packed {
    logic [I_ADDR_WIDTH-1:0] pc;
    logic [WARP_WIDTH-1:0]   mask;
    stk_kind_e               kind;
  } stk_entry_t;

  warp_state_e             state, state_d;
  logic [I_ADDR_WIDTH-1:0] pc, pc_d;
  logic [WARP_WIDTH-1:0]   mask, mask_d, taken;
  logic [BAR_W-1:0]        bar_idx, bar_d;
  logic                    err, err_d;
  logic                    hit_u, hit_i, hit_r, push, pop, full, empty;
  stk_entry_t              push_e, top_e;
  upd_kind_e               kind;

  assign kind  = upd_kind_e'(upd_kind);
  assign taken = upd_taken & mask;
  assign hit_u = upd_en && (upd_wid == wid_o) && (state != ST_IDLE);
  assign hit_i = issue_en && (issue_wid == wid_o) && (state == ST_READY);
  assign hit_r = rel_en && (rel_bid == bid_o) && (rel_bar == bar_idx);

  warp_rstack #(.DEPTH(STACK_DEPTH), .E_W($bits(stk_entry_t))) u_stk (
    .clk(clk), .rst(rst), .clr(init_en), .push(push), .pop(pop),
    .din(push_e), .top(top_e), .sp(sp_o), .full(full), .empty(empty)
  );

  always_comb begin
    state_d = state;
    pc_d    = pc;
    mask_d  = mask;
    bar_d   = bar_idx;
    err_d   = err;
    push    = 1'b0;
    pop     = 1'b0;
    push_e  = '0;
    if (init_en) begin
      state_d = ST_READY;
      pc_d    = init_pc;
      mask_d  = init_mask;
      err_d   = 1'b0;
    end else begin
      unique case (state)
        ST_READY: if (hit_i) state_d = ST_ISSUED;
        ST_ISSUED: if (hit_u) begin
          state_d = ST_READY;
          case (kind)
            UPD_NEXT: pc_d = upd_pc_p1;
            UPD_BRA: begin
              if (taken == '0) pc_d = upd_pc_p1;
              else if (taken == mask) pc_d = upd_target;
              else begin
                push   = 1'b1;
                push_e = '{pc: upd_pc_p1, mask: mask & ~taken, kind: STK_DIV};
                pc_d   = upd_target;
                mask_d = taken;
              end
            end
            UPD_SSY: begin
              push   = 1'b1;
              push_e = '{pc: upd_target, mask: mask, kind: STK_SYNC};
              pc_d   = upd_pc_p1;
            end
            UPD_SYNC: begin
              if (empty) begin
                err_d = 1'b1;
                pc_d  = upd_pc_p1;
              end else begin
                pop    = 1'b1;
                pc_d   = (top_e.kind == STK_DIV) ? top_e.pc : upd_pc_p1;
                mask_d = top_e.mask;
              end
            end
            UPD_BAR: begin
              pc_d  = upd_pc_p1;
              bar_d = upd_bar;
              // A release that lands with the BAR itself skips the wait state.
              if (!(rel_en && rel_bid == bid_o && rel_bar == upd_bar))
                state_d = ST_BAR_WAIT;
            end
            UPD_EXIT: state_d = ST_IDLE;
            default: ;
          endcase
          if (push && full) err_d = 1'b1;
        end
        ST_BAR_WAIT: if (hit_r) state_d = ST_READY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      mask        <= '0;
      bar_idx     <= '0;
      err         <= 1'b0;
      wid_o       <= '0;
      bid_o       <= '0;
      base_addr_o <= '0;
      rpt_o       <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      mask    <= mask_d;
      bar_idx <= bar_d;
      err     <= err_d;
      if (init_en) begin
        wid_o       <= init_wid;
        bid_o       <= init_bid;
        base_addr_o <= init_base;
        rpt_o       <= init_rpt;
      end
    end
  end

`ifdef WARP_SLOT_REPLAY_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) replay_cnt_o <= '0;
    else if (init_en) replay_cnt_o <= '0;
    else if (state == ST_ISSUED && hit_u && kind == UPD_REPLAY && replay_cnt_o != 8'hFF)
      replay_cnt_o <= replay_cnt_o + 8'd1;
  end
`endif

  assign ready      = (state == ST_READY);
  assign valid_o    = (state != ST_IDLE);
  assign bar_wait_o = (state == ST_BAR_WAIT);
  assign pc_o       = pc;
  assign mask_o     = mask;
  assign stk_err_o  = err;

endmodule

// File: tb/tb_warp_slot.sv
// Randomized bench for warp_slot (STACK_DEPTH=2) against a queue-based
// reference model of the slot's scheduling and reconvergence rules.
module tb_warp_slot;
  localparam int DEPTH = 2;

  logic        clk = 1'b0, rst = 1'b0;
  logic        init_en, issue_en, upd_en, rel_en;
  logic [3:0]  init_wid, issue_wid, upd_wid;
  logic [2:0]  init_bid, rel_bid, upd_kind;
  logic [9:0]  init_pc, init_base, init_rpt, upd_pc_p1, upd_target;
  logic [31:0] init_mask, upd_taken;
  logic [0:0]  upd_bar, rel_bar;
  logic        ready, valid_o, bar_wait_o, stk_err_o;
  logic [9:0]  pc_o, base_addr_o, rpt_o;
  logic [31:0] mask_o;
  logic [3:0]  wid_o;
  logic [2:0]  bid_o;
  logic [1:0]  sp_o;

  warp_slot #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .init_en(init_en), .init_wid(init_wid), .init_bid(init_bid),
    .init_pc(init_pc), .init_base(init_base), .init_rpt(init_rpt), .init_mask(init_mask),
    .issue_en(issue_en), .issue_wid(issue_wid), .upd_en(upd_en), .upd_wid(upd_wid),
    .upd_kind(upd_kind), .upd_pc_p1(upd_pc_p1), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_bar(upd_bar), .rel_en(rel_en), .rel_bid(rel_bid),
    .rel_bar(rel_bar), .ready(ready), .valid_o(valid_o), .pc_o(pc_o), .mask_o(mask_o),
    .wid_o(wid_o), .bid_o(bid_o), .base_addr_o(base_addr_o), .rpt_o(rpt_o),
    .bar_wait_o(bar_wait_o), .sp_o(sp_o), .stk_err_o(stk_err_o)
  );

  always #5 clk = ~clk;

  // Reference model: state as a name, stack as a queue of entries.
  typedef struct { logic [9:0] pc; logic [31:0] mask; bit div; } ent_t;
  ent_t        stk[$];
  string       m_st;
  logic [9:0]  m_pc, m_base, m_rpt;
  logic [31:0] m_mask;
  logic [3:0]  m_wid;
  logic [2:0]  m_bid;
  logic [0:0]  m_bar;
  bit          m_err;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_st = "IDLE"; m_pc = 0; m_mask = 0; m_wid = 0; m_bid = 0; m_base = 0; m_rpt = 0;
    m_bar = 0; m_err = 0; stk.delete();
  endfunction

  function automatic void model_push(input ent_t e);
    if (stk.size() == DEPTH) m_err = 1;
    else stk.push_back(e);
  endfunction

  function automatic void model_step();
    logic [31:0] t;
    ent_t e;
    if (init_en) begin
      m_st = "READY"; m_wid = init_wid; m_bid = init_bid; m_pc = init_pc; m_base = init_base;
      m_rpt = init_rpt; m_mask = init_mask; m_err = 0; stk.delete();
      return;
    end
    if (m_st == "READY" && issue_en && issue_wid == m_wid) m_st = "ISSUED";
    else if (m_st == "BAR_WAIT" && rel_en && rel_bid == m_bid && rel_bar == m_bar) m_st = "READY";
    else if (m_st == "ISSUED" && upd_en && upd_wid == m_wid) begin
      m_st = "READY";
      case (upd_kind)
        0: m_pc = upd_pc_p1;
        1: begin
          t = upd_taken & m_mask;
          if (t == 0) m_pc = upd_pc_p1;
          else if (t == m_mask) m_pc = upd_target;
          else begin
            e.pc = upd_pc_p1; e.mask = m_mask & ~t; e.div = 1;
            model_push(e);
            m_pc = upd_target; m_mask = t;
          end
        end
        2: begin
          e.pc = upd_target; e.mask = m_mask; e.div = 0;
          model_push(e);
          m_pc = upd_pc_p1;
        end
        3: begin
          if (stk.size() == 0) begin m_err = 1; m_pc = upd_pc_p1; end
          else begin
            e = stk.pop_back();
            m_pc = e.div ? e.pc : upd_pc_p1;
            m_mask = e.mask;
          end
        end
        4: begin
          m_pc = upd_pc_p1; m_bar = upd_bar;
          if (!(rel_en && rel_bid == m_bid && rel_bar == upd_bar)) m_st = "BAR_WAIT";
        end
        5: m_st = "IDLE";
        default: ;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, 64'(ready), 64'(m_st == "READY"));
    chk({tag, ".valid"}, 64'(valid_o), 64'(m_st != "IDLE"));
    chk({tag, ".barw"}, 64'(bar_wait_o), 64'(m_st == "BAR_WAIT"));
    chk({tag, ".pc"}, 64'(pc_o), 64'(m_pc));
    chk({tag, ".mask"}, 64'(mask_o), 64'(m_mask));
    chk({tag, ".wid"}, 64'(wid_o), 64'(m_wid));
    chk({tag, ".bid"}, 64'(bid_o), 64'(m_bid));
    chk({tag, ".base"}, 64'(base_addr_o), 64'(m_base));
    chk({tag, ".rpt"}, 64'(rpt_o), 64'(m_rpt));
    chk({tag, ".sp"}, 64'(sp_o), 64'(stk.size()));
    chk({tag, ".err"}, 64'(stk_err_o), 64'(m_err));
  endtask

  task automatic idle_in();
    init_en = 0; issue_en = 0; upd_en = 0; rel_en = 0;
    init_wid = 0; init_bid = 0; init_pc = 0; init_base = 0; init_rpt = 0; init_mask = 0;
    issue_wid = 0; upd_wid = 0; upd_kind = 0; upd_pc_p1 = 0; upd_target = 0;
    upd_taken = 0; upd_bar = 0; rel_bid = 0; rel_bar = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    idle_in();
  endtask

  task automatic do_issue();
    issue_en = 1; issue_wid = m_wid; step("issue");
  endtask

  task automatic do_upd(input int k, input logic [9:0] p1, input logic [9:0] tg,
                        input logic [31:0] tk, input logic b, input string tag);
    upd_en = 1; upd_wid = m_wid; upd_kind = 3'(k); upd_pc_p1 = p1; upd_target = tg;
    upd_taken = tk; upd_bar = b;
    step(tag);
  endtask

  task automatic do_init(input logic [3:0] w, input logic [2:0] b, input logic [9:0] p,
                         input logic [31:0] m);
    init_en = 1; init_wid = w; init_bid = b; init_pc = p; init_base = 10'h100;
    init_rpt = 10'h8; init_mask = m;
    step("init");
  endtask

  initial begin
    idle_in();
    model_reset();
    #3 check_all("reset");
    #10 rst = 1;

    do_init(4'd5, 3'd3, 10'h010, 32'hFFFF_FFFF);
    do_issue(); do_upd(0, 10'h011, 0, 0, 0, "next");
    chk("next.pc_const", 64'(pc_o), 64'h011);
    do_issue(); do_upd(2, 10'h012, 10'h040, 0, 0, "ssy");
    do_issue(); do_upd(1, 10'h012, 10'h020, 32'h0000_FFFF, 0, "bra_div");
    chk("bra.mask_const", 64'(mask_o), 64'h0000_FFFF);
    do_issue(); do_upd(3, 10'h021, 0, 0, 0, "sync_div");
    chk("sync_div.mask_const", 64'(mask_o), 64'hFFFF_0000);
    do_issue(); do_upd(3, 10'h013, 0, 0, 0, "sync_rec");
    chk("sync_rec.mask_const", 64'(mask_o), 64'hFFFF_FFFF);

    do_issue(); do_upd(4, 10'h014, 0, 0, 1, "bar");
    rel_en = 1; rel_bid = 3; rel_bar = 0; step("rel_wrong_bar");
    rel_en = 1; rel_bid = 2; rel_bar = 1; step("rel_wrong_bid");
    rel_en = 1; rel_bid = 3; rel_bar = 1; step("rel_ok");
    do_issue();
    rel_en = 1; rel_bid = 3; rel_bar = 0;
    do_upd(4, 10'h015, 0, 0, 0, "bar_same_cycle_rel");

    for (int i = 0; i < 3; i++) begin
      do_issue(); do_upd(2, 10'(10'h020 + i), 10'h080, 0, 0, "ssy_ovf");
    end
    chk("ovf.err_const", 64'(stk_err_o), 64'd1);
    do_init(4'd9, 3'd6, 10'h200, 32'h0F0F_0F0F);
    do_issue(); do_upd(3, 10'h201, 0, 0, 0, "sync_empty");

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63) == 0) begin
        init_en = 1; init_wid = 4'($urandom); init_bid = 3'($urandom);
        init_pc = 10'($urandom); init_base = 10'($urandom); init_rpt = 10'($urandom);
        init_mask = ($urandom_range(1) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      issue_en = 1'($urandom); issue_wid = $urandom_range(3) != 0 ? m_wid : 4'($urandom);
      upd_en = 1'($urandom); upd_wid = $urandom_range(3) != 0 ? m_wid : 4'($urandom);
      upd_kind = 3'($urandom_range(6)); upd_pc_p1 = 10'($urandom); upd_target = 10'($urandom);
      case ($urandom_range(3))
        0: upd_taken = 0;
        1: upd_taken = 32'hFFFF_FFFF;
        default: upd_taken = $urandom;
      endcase
      upd_bar = 1'($urandom);
      rel_en = ($urandom_range(2) == 0); rel_bar = 1'($urandom);
      rel_bid = $urandom_range(1) ? m_bid : 3'($urandom);
      step("rand");
    end

    do_init(4'd7, 3'd1, 10'h300, 32'hFFFF_FFFF);
    do_issue(); do_upd(5, 10'h301, 0, 0, 0, "exit");
    chk("exit.valid_const", 64'(valid_o), 64'd0);
    issue_en = 1; issue_wid = 4'd7; step("issue_after_exit");
    upd_en = 1; upd_wid = 4'd7; upd_kind = 0; upd_pc_p1 = 10'h3FF; step("upd_after_exit");

    do_init(4'd2, 3'd4, 10'h123, 32'hAAAA_5555);
    do_issue();
    #2 rst = 0;
    model_reset();
    #1 check_all("async_rst");
    chk("async_rst.pc_const", 64'(pc_o), 64'd0);
    @(negedge clk) rst = 1;
    step("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
